// File: rtl/storage_arbiter.sv
// Shares the single sample-RAM port between queued playback reads and loader writes.
// Reads return in issue order, tagged with their slot ID, a fixed latency after issue.
module storage_arbiter #(
    parameter int unsigned ADDR_U      = 22,
    parameter int unsigned ID_U        = 5,
    parameter int unsigned FIFO_LOG2   = 3,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_available,
    input  logic [ADDR_U:0]      address_in,
    input  logic [ID_U:0]        r_id_in,
    output logic [15:0]          data_out,
    output logic [ID_U:0]        r_id_out,
    output logic                 data_ready,
    input  logic                 wr_req,
    input  logic [ADDR_U:0]      wr_addr,
    input  logic [15:0]          wr_data,
    output logic                 wr_ack,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_U:0]      ram_addr,
    output logic [15:0]          ram_din,
    input  logic [15:0]          ram_dout,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic                 overflow
);
    localparam int unsigned AW    = ADDR_U + 1;
    localparam int unsigned IW    = ID_U + 1;
    localparam int unsigned PW    = FIFO_LOG2;
    localparam int unsigned LW    = FIFO_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_LOG2;

    logic [AW-1:0]        fifo_addr [DEPTH];
    logic [IW-1:0]        fifo_id   [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic                 last_read;
    logic [RAM_LATENCY:0] tag_valid;
    logic [IW-1:0]        tag_id    [RAM_LATENCY+1];

    logic wr_pend_c;
    logic fifo_ne_c;
    logic full_c;
    logic grant_rd_c;
    logic grant_wr_c;
    logic push_c;

    // Arbitration: on a conflict grant whichever type lost the previous conflict.
    always_comb begin
        wr_pend_c  = wr_req & ~wr_ack;
        fifo_ne_c  = (fifo_level != '0);
        full_c     = (fifo_level == LW'(DEPTH));
        grant_rd_c = fifo_ne_c & (~wr_pend_c | ~last_read);
        grant_wr_c = wr_pend_c & (~fifo_ne_c | last_read);
        push_c     = req_available & (~full_c | grant_rd_c);
    end

    // FIFO payload storage; occupancy and pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_addr[wr_ptr] <= address_in;
            fifo_id[wr_ptr]   <= r_id_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            last_read  <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            wr_ack     <= 1'b0;
            tag_valid  <= '0;
            for (int unsigned i = 0; i <= RAM_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
            data_ready <= 1'b0;
            data_out   <= '0;
            r_id_out   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_rd_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level <= fifo_level + LW'(push_c) - LW'(grant_rd_c);
            if (req_available && !push_c) begin
                overflow <= 1'b1;
            end
            if (wr_pend_c && fifo_ne_c) begin
                last_read <= grant_rd_c;
            end

            ram_en <= grant_rd_c | grant_wr_c;
            ram_we <= grant_wr_c;
            wr_ack <= grant_wr_c;
            if (grant_rd_c) begin
                ram_addr <= fifo_addr[rd_ptr];
            end else if (grant_wr_c) begin
                ram_addr <= wr_addr;
                ram_din  <= wr_data;
            end

            // Tag stage 0 sits alongside the issued address; stage RAM_LATENCY lines up with ram_dout.
            tag_valid <= {tag_valid[RAM_LATENCY-1:0], grant_rd_c};
            tag_id[0] <= fifo_id[rd_ptr];
            for (int unsigned i = 1; i <= RAM_LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end

            data_ready <= tag_valid[RAM_LATENCY];
            if (tag_valid[RAM_LATENCY]) begin
                data_out <= ram_dout;
                r_id_out <= tag_id[RAM_LATENCY];
            end
        end
    end
endmodule

// File: tb/tb_storage_arbiter.sv
// Randomized bench for storage_arbiter: a queue-based reference model predicts every
// registered output each cycle; a latency-L RAM model answers the DUT's RAM port.
module tb_storage_arbiter;
    localparam int L  = 2;
    localparam int AW = 23;
    localparam int IW = 6;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_available = 1'b0;
    logic [AW-1:0] address_in = '0;
    logic [IW-1:0] r_id_in = '0;
    logic [15:0]   data_out;
    logic [IW-1:0] r_id_out;
    logic          data_ready;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_ack;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout;
    logic [3:0]    fifo_level;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    storage_arbiter #(.ADDR_U(22), .ID_U(5), .FIFO_LOG2(3), .RAM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_available(req_available), .address_in(address_in),
        .r_id_in(r_id_in), .data_out(data_out), .r_id_out(r_id_out), .data_ready(data_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model (environment) ----------------
    logic [15:0] env_mem [int];
    logic [15:0] rd_dly [L];

    function automatic logic [15:0] dflt(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] env_rd(input logic [AW-1:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en && ram_we) env_mem[int'(ram_addr)] = ram_din;
    end

    always @(posedge clk) begin
        rd_dly[0] <= (ram_en && !ram_we) ? env_rd(ram_addr) : 16'hxxxx;
        for (int i = 1; i < L; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign ram_dout = rd_dly[L-1];

    // ---------------- Reference model ----------------
    typedef struct { logic [AW-1:0] a; logic [IW-1:0] id; } req_t;
    typedef struct { int due; logic [15:0] d; logic [IW-1:0] id; } ret_t;

    req_t        q[$];
    ret_t        fl[$];
    logic [15:0] ref_mem [int];
    int          cyc = 0;
    int          m_level = 0;
    int          n_acc = 0;
    bit          m_last_read, m_ack, m_en, m_we, m_dr, m_ovf, m_full_pop;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_din, m_dout;
    logic [IW-1:0] m_id;

    function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    task automatic model_reset();
        q.delete();
        fl.delete();
        m_last_read = 0; m_ack = 0; m_en = 0; m_we = 0; m_dr = 0; m_ovf = 0; m_full_pop = 0;
        m_addr = '0; m_din = '0; m_dout = '0; m_id = '0; m_level = 0;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied.
    task automatic model_eval();
        bit   wp, g_rd, g_wr;
        int   sz0;
        req_t r;
        ret_t t;
        if (reset) begin
            model_reset();
            return;
        end
        cyc++;
        m_dr = 0;
        if (fl.size() > 0 && fl[0].due == cyc) begin
            t = fl.pop_front();
            m_dr = 1; m_dout = t.d; m_id = t.id;
        end
        wp  = wr_req && !m_ack;
        sz0 = q.size();
        if (sz0 > 0 && wp) begin
            g_rd = !m_last_read;
            g_wr = m_last_read;
            m_last_read = g_rd;
        end else begin
            g_rd = (sz0 > 0);
            g_wr = wp;
        end
        m_en = g_rd || g_wr; m_we = g_wr; m_ack = g_wr;
        if (g_rd) begin
            r = q.pop_front();
            m_addr = r.a;
            t.due = cyc + L + 1; t.d = ref_rd(r.a); t.id = r.id;
            fl.push_back(t);
        end
        if (g_wr) begin
            m_addr = wr_addr; m_din = wr_data;
            ref_mem[int'(wr_addr)] = wr_data;
        end
        m_full_pop = req_available && sz0 == D && g_rd;
        if (req_available) begin
            if (sz0 < D || g_rd) begin
                r.a = address_in; r.id = r_id_in;
                q.push_back(r);
                n_acc++;
            end else begin
                m_ovf = 1;
            end
        end
        m_level = q.size();
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [69:0] dut_vec();
        return {data_ready, wr_ack, ram_en, ram_we, overflow, fifo_level, ram_addr, ram_din, data_out, r_id_out};
    endfunction

    function automatic logic [69:0] mdl_vec();
        return {m_dr, m_ack, m_en, m_we, m_ovf, 4'(m_level), m_addr, m_din, m_dout, m_id};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; req_available = 1'b0; wr_req = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== '0) begin n_err++; $display("FAIL reset_async got %h exp 0", dut_vec()); end
        @(negedge clk);
        step();
        n_cmp++;
        if (dut_vec() !== '0) begin n_err++; $display("FAIL reset_hold got %h exp 0", dut_vec()); end
        @(negedge clk);
        reset = 1'b0;
        step();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL reset_release got %h exp %h", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_single_read();
        bit got = 0;
        int lat = 0;
        @(negedge clk);
        req_available = 1'b1; address_in = 23'h000010; r_id_in = 6'd7;
        step();
        n_cmp++;
        if (fifo_level !== 4'd1 || dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL single_push lvl=%0d exp 1 got %h exp %h", fifo_level, dut_vec(), mdl_vec());
        end
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            req_available = 1'b0;
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL single_cyc k=%0d got %h exp %h", k, dut_vec(), mdl_vec()); end
            if (data_ready) begin got = 1; lat = k; end
        end
        n_cmp++;
        if (!got || lat != 4 || data_out !== 16'hBEEF || r_id_out !== 6'd7 || fifo_level !== 4'd0) begin
            n_err++;
            $display("FAIL single_read got=%0b lat=%0d data=%h id=%0d lvl=%0d exp lat=4 data=beef id=7 lvl=0",
                     got, lat, data_out, r_id_out, fifo_level);
        end
    endtask

    task automatic test_burst();
        int acc0 = n_acc;
        int n_ret = 0;
        int last_id = -1;
        for (int s = 0; s < 45; s++) begin
            @(negedge clk);
            req_available = (s < 31);
            address_in = 23'($urandom_range(0, 63));
            r_id_in = 6'(s);
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL burst cyc=%0d got %h exp %h", cyc, dut_vec(), mdl_vec()); end
            if (data_ready) begin
                n_ret++;
                n_cmp++;
                if (int'(r_id_out) <= last_id) begin n_err++; $display("FAIL burst_order id=%0d after %0d", r_id_out, last_id); end
                last_id = int'(r_id_out);
            end
        end
        n_cmp++;
        if (n_ret != n_acc - acc0) begin n_err++; $display("FAIL burst_count returned=%0d exp %0d", n_ret, n_acc - acc0); end
    endtask

    task automatic test_overflow_full_pop();
        bit ovf_before;
        bit seen_fp = 0;
        pulse_reset();
        wr_req = 1'b1; wr_addr = 23'h200; wr_data = 16'h0;
        for (int s = 0; s < 80; s++) begin
            @(negedge clk);
            if (m_ack) begin
                wr_req  = (s < 48);
                wr_addr = 23'(32'h200 + s);
                wr_data = 16'($urandom);
            end
            req_available = (s < 48);
            address_in = 23'($urandom_range(0, 63));
            r_id_in = 6'(s);
            ovf_before = m_ovf;
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL ovf_cyc cyc=%0d got %h exp %h", cyc, dut_vec(), mdl_vec()); end
            if (m_full_pop && !ovf_before) begin
                seen_fp = 1;
                n_cmp++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    n_err++; $display("FAIL full_pop lvl=%0d ovf=%b exp lvl=8 ovf=0", fifo_level, overflow);
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || !seen_fp) begin
            n_err++; $display("FAIL overflow_sticky ovf=%b full_pop_seen=%0b exp 1 1", overflow, seen_fp);
        end
    endtask

    task automatic test_contention();
        int  acks = 0;
        int  writes = 0;
        bit  got9 = 0;
        pulse_reset();
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            req_available = (s <= 4) || (s == 6);
            address_in = (s == 6) ? 23'h100 : 23'(s * 4);
            r_id_in = (s == 6) ? 6'd9 : 6'(s);
            wr_req = (s >= 2 && s <= 4);
            wr_addr = 23'h100; wr_data = 16'h1234;
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL cont_cyc s=%0d got %h exp %h", s, dut_vec(), mdl_vec()); end
            if (wr_ack) acks++;
            if (ram_en && ram_we) writes++;
            if (s == 2) begin
                n_cmp++;
                if ({ram_en, ram_we, wr_ack} !== 3'b100) begin n_err++; $display("FAIL cont_first_read en/we/ack=%b exp 100", {ram_en, ram_we, wr_ack}); end
            end
            if (s == 3) begin
                n_cmp++;
                if ({ram_en, ram_we, wr_ack} !== 3'b111 || ram_addr !== 23'h100 || ram_din !== 16'h1234) begin
                    n_err++; $display("FAIL cont_write en/we/ack=%b addr=%h din=%h exp 111 100 1234", {ram_en, ram_we, wr_ack}, ram_addr, ram_din);
                end
            end
            if (s == 4) begin
                n_cmp++;
                if ({ram_en, ram_we, wr_ack} !== 3'b100) begin n_err++; $display("FAIL cont_no_reissue en/we/ack=%b exp 100", {ram_en, ram_we, wr_ack}); end
            end
            if (data_ready && r_id_out === 6'd9) begin
                got9 = 1;
                n_cmp++;
                if (data_out !== 16'h1234) begin n_err++; $display("FAIL cont_readback data=%h exp 1234", data_out); end
            end
        end
        n_cmp++;
        if (acks != 1 || writes != 1 || !got9 || env_rd(23'h100) !== 16'h1234) begin
            n_err++; $display("FAIL cont_summary acks=%0d writes=%0d readback=%0b mem=%h exp 1 1 1 1234", acks, writes, got9, env_rd(23'h100));
        end
    endtask

    task automatic test_reset_midflight();
        bit ready = 0;
        pulse_reset();
        wr_req = 1'b1; wr_addr = 23'h300; wr_data = 16'h5555;
        for (int s = 0; s < 40 && !ready; s++) begin
            @(negedge clk);
            if (m_ack) begin wr_addr = 23'(32'h300 + s); wr_data = 16'($urandom); end
            req_available = 1'b1;
            address_in = 23'($urandom_range(0, 63));
            r_id_in = 6'(s);
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL midfill cyc=%0d got %h exp %h", cyc, dut_vec(), mdl_vec()); end
            ready = (q.size() >= 3) && (fl.size() >= 2);
        end
        n_cmp++;
        if (!ready) begin n_err++; $display("FAIL midflight_setup fifo=%0d inflight=%0d exp >=3 >=2", q.size(), fl.size()); end
        #2;
        reset = 1'b1; req_available = 1'b0; wr_req = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== '0) begin n_err++; $display("FAIL midflight_async got %h exp 0", dut_vec()); end
        @(negedge clk);
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            if (s > 0) @(negedge clk);
            step();
            n_cmp++;
            if (data_ready !== 1'b0 || fifo_level !== 4'd0 || dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL midflight_after s=%0d dr=%b lvl=%0d exp 0 0 got %h exp %h", s, data_ready, fifo_level, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 330; s++) begin
            @(negedge clk);
            if (wr_req && m_ack) begin
                wr_req = 1'b0;
            end else if (!wr_req && s < 300 && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wr_addr = 23'($urandom_range(0, 63));
                wr_data = 16'($urandom);
            end
            req_available = (s < 300) && ($urandom_range(0, 3) != 0);
            address_in = 23'($urandom_range(0, 63));
            r_id_in = 6'($urandom);
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin n_err++; $display("FAIL random cyc=%0d got %h exp %h", cyc, dut_vec(), mdl_vec()); end
        end
    endtask

    initial begin
        env_mem[16] = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        for (int i = 0; i < L; i++) rd_dly[i] = 16'h0;
        test_reset();
        test_single_read();
        test_burst();
        test_overflow_full_pop();
        test_contention();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
